spi_display_tx: RTL and testbench

SPI_DISPLAY_TX -- requirements
Module: spi_display_tx

---
 rtl/spi_display_tx.sv | 141 ++++++++++++++
 tb/tb_spi_display_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_display_tx.sv
// Byte-wide SPI (mode 0) transmitter for small displays: a FIFO of {dc, byte}
// entries feeds a shifter that frames consecutive bytes under a single chip select.
module spi_display_tx #(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wrData,
    input  logic                     wrDc,
    input  logic                     wrValid,
    output logic                     wrReady,
    output logic                     mosi,
    output logic                     sclk,
    output logic                     cs,
    output logic                     dc,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifoCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t          state, state_next;
    logic [8:0]      mem [DEPTH];
    logic [8:0]      head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;
    logic [DW-1:0]   div, div_next;
    logic            tick;
    logic [3:0]      toggles, toggles_next;
    logic [7:0]      shreg, shreg_next;
    logic            sclk_next, cs_next, dc_next;

    assign wrReady   = (count < (AW+1)'(DEPTH));
    assign push      = wrValid && wrReady && !rst;
    assign fifoCount = count;
    assign busy      = (state != IDLE);
    assign mosi      = shreg[7];
    assign tick      = (div == DW'(CLK_DIV - 1));
    assign head      = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; reset flushes by clearing them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wrDc, wrData};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            toggles <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            dc      <= 1'b0;
        end else begin
            state   <= state_next;
            div     <= div_next;
            toggles <= toggles_next;
            shreg   <= shreg_next;
            sclk    <= sclk_next;
            cs      <= cs_next;
            dc      <= dc_next;
        end
    end

    always_comb begin
        state_next   = state;
        div_next     = tick ? '0 : DW'(div + 1'b1);
        toggles_next = toggles;
        shreg_next   = shreg;
        sclk_next    = sclk;
        cs_next      = cs;
        dc_next      = dc;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                cs_next      = 1'b1;
                sclk_next    = 1'b0;
                div_next     = '0;
                toggles_next = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    shreg_next = head[7:0];
                    dc_next    = head[8];
                    cs_next    = 1'b0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sclk_next    = ~sclk;
                    toggles_next = toggles + 4'd1;
                    // Falling toggle: next bit goes out, or the frame ends after the 16th toggle.
                    if (sclk) begin
                        shreg_next = {shreg[6:0], 1'b0};
                        if (toggles == 4'd15) begin
                            toggles_next = '0;
                            if (count != '0) begin
                                pop        = 1'b1;
                                shreg_next = head[7:0];
                                dc_next    = head[8];
                                state_next = SETUP;
                            end else begin
                                state_next = HOLD;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_next    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_display_tx.sv
// Directed self-checking bench for spi_display_tx: one instance at CLK_DIV=2
// for framing, burst, reset and overflow, one at CLK_DIV=1 for fast timing.
module tb_spi_display_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wrData;
    logic       wrDc, wrValid;
    logic       wrReady, mosi, sclk, cs, dc, busy;
    logic [2:0] fifoCount;

    logic [7:0] bData;
    logic       bDc, bValid;
    logic       bReady, bMosi, bSclk, bCs, bDcOut, bBusy;
    logic [2:0] bCount;

    int checks = 0;
    int errors = 0;

    spi_display_tx #(.DEPTH(4), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .wrData(wrData), .wrDc(wrDc), .wrValid(wrValid),
        .wrReady(wrReady), .mosi(mosi), .sclk(sclk), .cs(cs), .dc(dc),
        .busy(busy), .fifoCount(fifoCount)
    );

    spi_display_tx #(.DEPTH(4), .CLK_DIV(1)) dutFast (
        .clk(clk), .rst(rst), .wrData(bData), .wrDc(bDc), .wrValid(bValid),
        .wrReady(bReady), .mosi(bMosi), .sclk(bSclk), .cs(bCs), .dc(bDcOut),
        .busy(bBusy), .fifoCount(bCount)
    );

    always #5 clk = ~clk;

    // Line monitor: rebuilds bytes on rising sclk and tallies framing violations.
    int         rises = 0, csRises = 0, csBad = 0, mosiBad = 0, dcBad = 0, nbits = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] byteQ[$];
    logic       dcQ[$];
    logic       pSclk = 1'b0, pMosi = 1'b0, pDc = 1'b0, pCs = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
        end else begin
            if (!pSclk && sclk) begin
                rises++;
                if (cs) csBad++;
                cur = {cur[6:0], mosi};
                nbits++;
                if (nbits == 8) begin
                    byteQ.push_back(cur);
                    dcQ.push_back(dc);
                    nbits = 0;
                end
            end
            if (mosi !== pMosi && sclk) mosiBad++;
            if (dc !== pDc && sclk) dcBad++;
            if (!pCs && cs) csRises++;
        end
        pSclk = sclk; pMosi = mosi; pDc = dc; pCs = cs;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic t);
        wrData  = d;
        wrDc    = t;
        wrValid = 1'b1;
        @(posedge clk); #1;
        wrValid = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n = 0;
        while ((busy || fifoCount != 3'd0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(tag, 32'(n < limit), 32'd1);
    endtask

    initial begin
        int         base, rbase, csBase, n, acc, guard, firstRise, secondRise, fastRises;
        logic       sawBlock, overFull, prevS;
        logic [7:0] d, fastByte;
        logic [7:0] expQ[$];

        rst = 1'b1; wrData = 8'hFF; wrDc = 1'b1; wrValid = 1'b1;
        bData = 8'h00; bDc = 1'b0; bValid = 1'b0;
        repeat (2) @(posedge clk); #1;
        checkOutput("reset cs", cs, 1'b1);
        checkOutput("reset sclk", sclk, 1'b0);
        checkOutput("reset mosi", mosi, 1'b0);
        checkOutput("reset dc", dc, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset count", fifoCount, 3'd0);
        checkOutput("reset wrReady", wrReady, 1'b1);
        wrValid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("no write during reset", fifoCount, 3'd0);

        // Single command 0xAE
        base = byteQ.size(); rbase = rises;
        applyStimulus(8'hAE, 1'b0);
        checkOutput("single accept count", fifoCount, 3'd1);
        checkOutput("single cs before load", cs, 1'b1);
        @(posedge clk); #1;
        checkOutput("single cs low", cs, 1'b0);
        checkOutput("single popped", fifoCount, 3'd0);
        checkOutput("single busy", busy, 1'b1);
        checkOutput("single first bit", mosi, 1'b1);
        n = 0;
        while (cs == 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("single cs low clocks", n, 36);
        checkOutput("single busy after", busy, 1'b0);
        checkOutput("single rises", rises - rbase, 8);
        checkOutput("single byte count", byteQ.size() - base, 1);
        if (byteQ.size() > base) begin
            checkOutput("single byte", byteQ[base], 8'hAE);
            checkOutput("single dc", dcQ[base], 1'b0);
        end

        // Burst of five data bytes with wrValid held
        base = byteQ.size(); rbase = rises; csBase = csRises;
        wrDc = 1'b1; wrData = 8'h01; wrValid = 1'b1;
        acc = 0; guard = 0;
        while (acc < 5 && guard < 100) begin
            prevS = wrReady;
            @(posedge clk); #1;
            guard++;
            if (prevS) begin
                acc++;
                wrData = 8'h01 + 8'(acc);
            end
        end
        wrValid = 1'b0;
        checkOutput("burst accepted", acc, 5);
        checkOutput("burst full count", fifoCount, 3'd4);
        checkOutput("burst wrReady low", wrReady, 1'b0);
        waitIdle("burst finish", 1000);
        checkOutput("burst rises", rises - rbase, 40);
        checkOutput("burst cs rises", csRises - csBase, 1);
        checkOutput("burst byte count", byteQ.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            if (byteQ.size() > base + i) begin
                checkOutput($sformatf("burst byte %0d", i), byteQ[base+i], 8'(i + 1));
                checkOutput($sformatf("burst dc %0d", i), dcQ[base+i], 1'b1);
            end
        end

        // Command then data back-to-back
        base = byteQ.size();
        wrData = 8'h2A; wrDc = 1'b0; wrValid = 1'b1;
        @(posedge clk); #1;
        wrData = 8'h55; wrDc = 1'b1;
        @(posedge clk); #1;
        wrValid = 1'b0;
        waitIdle("mixed finish", 1000);
        checkOutput("mixed byte count", byteQ.size() - base, 2);
        if (byteQ.size() > base + 1) begin
            checkOutput("mixed byte0", byteQ[base], 8'h2A);
            checkOutput("mixed dc0", dcQ[base], 1'b0);
            checkOutput("mixed byte1", byteQ[base+1], 8'h55);
            checkOutput("mixed dc1", dcQ[base+1], 1'b1);
        end
        checkOutput("dc stable while sclk high", dcBad, 0);
        checkOutput("mosi stable while sclk high", mosiBad, 0);
        checkOutput("cs low at every rise", csBad, 0);

        // Reset after the third rising edge with two entries queued
        rbase = rises;
        wrDc = 1'b1; wrValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrData = 8'h81 + 8'(i);
            @(posedge clk); #1;
        end
        wrValid = 1'b0;
        n = 0;
        while (rises - rbase < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("midbyte reached 3rd rise", 32'(n < 200), 32'd1);
        checkOutput("midbyte queued", fifoCount, 3'd2);
        rst = 1'b1;
        #1;
        checkOutput("async reset cs", cs, 1'b1);
        checkOutput("async reset sclk", sclk, 1'b0);
        checkOutput("async reset count", fifoCount, 3'd0);
        checkOutput("async reset busy", busy, 1'b0);
        checkOutput("async reset mosi", mosi, 1'b0);
        wrData = 8'h99; wrValid = 1'b1;
        repeat (2) @(posedge clk); #1;
        checkOutput("wrReady during reset", wrReady, 1'b1);
        wrValid = 1'b0;
        rst = 1'b0;
        rbase = rises; base = byteQ.size();
        repeat (60) @(posedge clk); #1;
        checkOutput("no sclk after release", rises - rbase, 0);
        checkOutput("no byte after release", byteQ.size() - base, 0);
        checkOutput("idle after release", cs, 1'b1);
        checkOutput("flushed after release", fifoCount, 3'd0);

        // Overflow: hold wrValid far longer than the FIFO can absorb
        base = byteQ.size();
        sawBlock = 1'b0; overFull = 1'b0;
        d = 8'h10; wrData = d; wrDc = 1'b1; wrValid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            prevS = wrReady;
            if (!prevS) sawBlock = 1'b1;
            @(posedge clk); #1;
            if (fifoCount > 3'd4) overFull = 1'b1;
            if (prevS) begin
                expQ.push_back(d);
                d = d + 8'd1;
                wrData = d;
            end
        end
        wrValid = 1'b0;
        checkOutput("overflow blocked", sawBlock, 1'b1);
        checkOutput("overflow count bound", overFull, 1'b0);
        waitIdle("overflow finish", 2000);
        checkOutput("overflow sent equals accepted", byteQ.size() - base, expQ.size());
        foreach (expQ[i]) begin
            if (byteQ.size() > base + i)
                checkOutput($sformatf("overflow byte %0d", i), byteQ[base+i], expQ[i]);
        end

        // CLK_DIV=1 single byte
        bData = 8'hC3; bDc = 1'b1; bValid = 1'b1;
        @(posedge clk); #1;
        bValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("fast cs low", bCs, 1'b0);
        n = 0; firstRise = -1; secondRise = -1; fastRises = 0; fastByte = 8'h00;
        prevS = bSclk;
        while (bCs == 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!prevS && bSclk) begin
                fastRises++;
                fastByte = {fastByte[6:0], bMosi};
                if (firstRise < 0) firstRise = n;
                else if (secondRise < 0) secondRise = n;
            end
            prevS = bSclk;
        end
        checkOutput("fast first rise", firstRise, 2);
        checkOutput("fast sclk period", secondRise - firstRise, 2);
        checkOutput("fast cs low clocks", n, 18);
        checkOutput("fast rises", fastRises, 8);
        checkOutput("fast byte", fastByte, 8'hC3);
        checkOutput("fast dc", bDcOut, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
